// File: rtl/evr_trig_pkg.sv
// evr_trig_pkg: shared FSM state encoding, default parameter values and a
// small helper used by the EVR trigger conditioner.
package evr_trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    PULSE   = 2'd2,
    HOLDOFF = 2'd3
  } evr_trig_state_t;

  localparam int DEF_FILTER_CYCLES  = 4;
  localparam int DEF_DELAY_CYCLES   = 16;
  localparam int DEF_PULSE_CYCLES   = 600;
  localparam int DEF_HOLDOFF_CYCLES = 1000;
  localparam int DEF_CNT_W          = 16;

  // Largest of three phase lengths, used to size the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/evr_sync_filter.sv
// evr_sync_filter: brings the asynchronous EVR trigger into the clk domain,
// rejects glitches shorter than the filter window and flags the filtered
// rising edge. An edge is only reported once the line has been seen low
// after reset, so a line that is already high at reset release cannot fire.
module evr_sync_filter
  import evr_trig_pkg::*;
#(
  parameter int FILTER_CYCLES = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic evr_trigger_in,
  output logic rise
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          filt;
  logic          filt_q;
  logic          armed;
  logic [1:0]    prime_q;
  logic [FW-1:0] filt_cnt;

  // Two-flop synchronizer for the raw trigger line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= evr_trigger_in;
      sync2 <= sync1;
    end
  end

  // Arm edge detection once a genuinely sampled low has left the synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prime_q <= 2'b00;
      armed   <= 1'b0;
    end else begin
      prime_q <= {prime_q[0], 1'b1};
      if (prime_q[1] && !sync2) begin
        armed <= 1'b1;
      end
    end
  end

  // Filtered level follows sync2 only after it has disagreed long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt     <= 1'b0;
      filt_cnt <= '0;
    end else if (sync2 == filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_CYCLES)) begin
      filt     <= sync2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  // One-cycle delayed copy of the filtered level for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 1'b0;
    end else begin
      filt_q <= filt;
    end
  end

  assign rise = filt & ~filt_q & armed;

endmodule

// File: rtl/evr_trigger_conditioner.sv
// evr_trigger_conditioner: turns the raw EVR trigger into a clean pulse of
// fixed width after a fixed delay, followed by a holdoff that rejects
// re-triggers. Defining EVR_TRIG_STATS_EN adds pulse and missed-edge counters.
module evr_trigger_conditioner
  import evr_trig_pkg::*;
#(
  parameter int FILTER_CYCLES  = DEF_FILTER_CYCLES,
  parameter int DELAY_CYCLES   = DEF_DELAY_CYCLES,
  parameter int PULSE_CYCLES   = DEF_PULSE_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             evr_trigger_in,
  output logic             evr_trigger,
  output logic             busy
`ifdef EVR_TRIG_STATS_EN
  ,
  output logic [CNT_W-1:0] trig_count,
  output logic [CNT_W-1:0] missed_count
`endif
);

  localparam int CNT_MAX = max3(DELAY_CYCLES, PULSE_CYCLES, HOLDOFF_CYCLES);
  localparam int SW      = $clog2(CNT_MAX + 1);

  localparam logic [SW-1:0] DELAY_LAST   = SW'(DELAY_CYCLES - 1);
  localparam logic [SW-1:0] PULSE_LAST   = SW'(PULSE_CYCLES - 1);
  localparam logic [SW-1:0] HOLDOFF_LAST = SW'(HOLDOFF_CYCLES - 1);

  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255 ||
      PULSE_CYCLES < 1 || PULSE_CYCLES > 65535 ||
      DELAY_CYCLES < 0 || HOLDOFF_CYCLES < 0 || CNT_W < 1) begin : g_bad_params
    $error("evr_trigger_conditioner: parameter out of legal range");
  end

  evr_trig_state_t state;
  evr_trig_state_t next_state;
  logic [SW-1:0]   cnt;
  logic [SW-1:0]   cnt_next;
  logic            rise;

  evr_sync_filter #(
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_sync_filter (
    .clk            (clk),
    .reset          (reset),
    .evr_trigger_in (evr_trigger_in),
    .rise           (rise)
  );

  // Next state and phase counter; the counter restarts on every state change.
  always_comb begin
    next_state = state;
    cnt_next   = '0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (DELAY_CYCLES == 0) begin
            next_state = PULSE;
          end else begin
            next_state = DELAY;
          end
        end
      end
      DELAY: begin
        if (cnt == DELAY_LAST) begin
          next_state = PULSE;
        end
      end
      PULSE: begin
        if (cnt == PULSE_LAST) begin
          if (HOLDOFF_CYCLES == 0) begin
            next_state = IDLE;
          end else begin
            next_state = HOLDOFF;
          end
        end
      end
      HOLDOFF: begin
        if (cnt == HOLDOFF_LAST) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (next_state == state && state != IDLE) begin
      cnt_next = cnt + SW'(1);
    end
  end

  // State and phase counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Outputs are registered from the next state so they align with the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      evr_trigger <= 1'b0;
      busy        <= 1'b0;
    end else begin
      evr_trigger <= (next_state == PULSE);
      busy        <= (next_state != IDLE);
    end
  end

`ifdef EVR_TRIG_STATS_EN
  // Pulse counter wraps; missed-edge counter sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_count   <= '0;
      missed_count <= '0;
    end else begin
      if (next_state == PULSE && state != PULSE) begin
        trig_count <= trig_count + CNT_W'(1);
      end
      if (rise && state != IDLE && missed_count != {CNT_W{1'b1}}) begin
        missed_count <= missed_count + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_evr_trigger_conditioner.sv
// tb_evr_trigger_conditioner: drives two conditioner instances (default
// timing, and zero delay / zero holdoff with a short pulse) and compares them
// against a timestamp-based reference model every cycle, plus directed
// vectors for latency, re-trigger rejection and reset behaviour.
module tb_evr_trigger_conditioner;

  localparam int A_F = 4;
  localparam int A_D = 16;
  localparam int A_P = 600;
  localparam int A_H = 1000;
  localparam int B_F = 4;
  localparam int B_D = 0;
  localparam int B_P = 20;
  localparam int B_H = 0;
  localparam int CNT_W = 16;

  typedef struct {
    int low_c;
    int high_c;
    int exp_pulses;
    int exp_missed;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic in_a;
  logic in_b;
  logic trig_a;
  logic trig_b;
  logic busy_a;
  logic busy_b;
`ifdef EVR_TRIG_STATS_EN
  logic [CNT_W-1:0] tc_a;
  logic [CNT_W-1:0] mc_a;
  logic [CNT_W-1:0] tc_b;
  logic [CNT_W-1:0] mc_b;
`endif

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  int pf [2] = '{A_F, B_F};
  int pd [2] = '{A_D, B_D};
  int pp [2] = '{A_P, B_P};
  int ph [2] = '{A_H, B_H};
  string nm [2] = '{"a", "b"};

  // reference model state: event timestamps in cycles since reset release
  logic [63:0] hist [2];
  bit          filt_m [2];
  bit          armed_m [2];
  longint      kc [2];
  longint      rise_at [2];
  longint      acc_r [2];
  longint      s_m [2];
  longint      end_m [2];
  int          missed_m [2];
  int          pulses_m [2];
  bit          exp_trig [2];
  bit          exp_busy [2];

  // observed pulse statistics
  int     seen [2];
  int     wid [2];
  bit     prev_trig [2];
  longint rise_cyc [2];
  longint last_hi [2];

  vec_t tbl [6];

  evr_trigger_conditioner #(
    .FILTER_CYCLES (A_F), .DELAY_CYCLES (A_D), .PULSE_CYCLES (A_P),
    .HOLDOFF_CYCLES (A_H), .CNT_W (CNT_W)
  ) dut_a (
    .clk (clk), .reset (reset), .evr_trigger_in (in_a),
    .evr_trigger (trig_a), .busy (busy_a)
`ifdef EVR_TRIG_STATS_EN
    , .trig_count (tc_a), .missed_count (mc_a)
`endif
  );

  evr_trigger_conditioner #(
    .FILTER_CYCLES (B_F), .DELAY_CYCLES (B_D), .PULSE_CYCLES (B_P),
    .HOLDOFF_CYCLES (B_H), .CNT_W (CNT_W)
  ) dut_b (
    .clk (clk), .reset (reset), .evr_trigger_in (in_b),
    .evr_trigger (trig_b), .busy (busy_b)
`ifdef EVR_TRIG_STATS_EN
    , .trig_count (tc_b), .missed_count (mc_b)
`endif
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // free-running edge counter used for latency measurements
  always @(posedge clk) cyc++;

  function automatic logic dut_trig(input int m);
    return (m == 0) ? trig_a : trig_b;
  endfunction

  function automatic logic dut_busy(input int m);
    return (m == 0) ? busy_a : busy_b;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input int m, input logic v);
    if (m == 0) in_a = v;
    else        in_b = v;
  endtask

  // low for low_c cycles, then high for high_c cycles (skipped when zero)
  task automatic applyStimulus(input int m, input int low_c, input int high_c);
    drive(m, 1'b0);
    repeat (low_c) @(negedge clk);
    if (high_c > 0) begin
      drive(m, 1'b1);
      last_hi[m] = cyc + 1;
      repeat (high_c) @(negedge clk);
    end
  endtask

  task automatic modelReset(input int m);
    hist[m]     = '0;
    filt_m[m]   = 1'b0;
    armed_m[m]  = 1'b0;
    kc[m]       = 0;
    rise_at[m]  = -1;
    acc_r[m]    = -1000000;
    s_m[m]      = -1000000;
    end_m[m]    = -1;
    missed_m[m] = 0;
    pulses_m[m] = 0;
    exp_trig[m] = 1'b0;
    exp_busy[m] = 1'b0;
  endtask

  // One clock of the model: filtered level flips when the last F+1 synced
  // samples all disagree with it; an accepted edge schedules a pulse window
  // and a busy window, any edge landing inside the busy window is missed.
  task automatic modelStep(input int m, input logic x);
    longint k;
    bit     differ;
    k = kc[m];
    hist[m] = {hist[m][62:0], x};
    if (rise_at[m] == k) begin
      if (k > end_m[m]) begin
        acc_r[m] = k;
        s_m[m]   = k + pd[m];
        end_m[m] = s_m[m] + pp[m] + ph[m];
      end else if (missed_m[m] < (1 << CNT_W) - 1) begin
        missed_m[m]++;
      end
    end
    if (k >= 2 && hist[m][2] == 1'b0) armed_m[m] = 1'b1;
    differ = 1'b1;
    for (int j = 0; j <= pf[m]; j++) begin
      if (hist[m][2 + j] == filt_m[m]) differ = 1'b0;
    end
    if (differ) begin
      filt_m[m] = ~filt_m[m];
      if (filt_m[m] && armed_m[m]) rise_at[m] = k + 1;
    end
    if (k == s_m[m]) pulses_m[m]++;
    exp_trig[m] = (k >= s_m[m]) && (k < s_m[m] + pp[m]);
    exp_busy[m] = (k >= acc_r[m]) && (k < end_m[m]);
    kc[m] = k + 1;
  endtask

  // reference model advances on every clock, cleared by reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) modelReset(m);
    end else begin
      modelStep(0, in_a);
      modelStep(1, in_b);
    end
  end

  // per-cycle comparison against the model and pulse width/edge monitor
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      checkOutput({nm[m], "_evr_trigger"}, 64'(dut_trig(m)), 64'(exp_trig[m]));
      checkOutput({nm[m], "_busy"}, 64'(dut_busy(m)), 64'(exp_busy[m]));
      if (reset) begin
        wid[m] = 0;
      end else if (dut_trig(m) === 1'b1) begin
        if (!prev_trig[m]) begin
          seen[m]++;
          rise_cyc[m] = cyc;
        end
        wid[m]++;
      end else if (wid[m] != 0) begin
        checkOutput({nm[m], "_pulse_width"}, 64'(wid[m]), 64'(pp[m]));
        wid[m] = 0;
      end
      prev_trig[m] = (dut_trig(m) === 1'b1) && !reset;
    end
  end

  initial begin
    reset = 1'b1;
    in_a  = 1'b0;
    in_b  = 1'b0;
    for (int m = 0; m < 2; m++) begin
      seen[m] = 0; wid[m] = 0; prev_trig[m] = 1'b0;
      rise_cyc[m] = 0; last_hi[m] = 0;
    end
    tbl[0] = '{1500, 100, 1, 0};
    tbl[1] = '{100, 100, 1, 1};
    tbl[2] = '{723, 100, 1, 2};
    tbl[3] = '{600, 700, 2, 2};
    tbl[4] = '{3000, 3, 2, 2};
    tbl[5] = '{50, 0, 2, 2};

    repeat (3) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_a_trig", 64'(trig_a), 64'd0);
    checkOutput("reset_a_busy", 64'(busy_a), 64'd0);
    checkOutput("reset_b_trig", 64'(trig_b), 64'd0);
`ifdef EVR_TRIG_STATS_EN
    checkOutput("reset_a_trig_count", 64'(tc_a), 64'd0);
    checkOutput("reset_a_missed_count", 64'(mc_a), 64'd0);
`endif
    reset = 1'b0;

    $display("[TB] directed vectors: latency, retrigger rejection, glitch");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, tbl[i].low_c, tbl[i].high_c);
      checkOutput("tbl_pulses", 64'(seen[0]), 64'(tbl[i].exp_pulses));
`ifdef EVR_TRIG_STATS_EN
      checkOutput("tbl_trig_count", 64'(tc_a), 64'(tbl[i].exp_pulses));
      checkOutput("tbl_missed_count", 64'(mc_a), 64'(tbl[i].exp_missed));
`endif
      if (i == 0) begin
        checkOutput("latency_a", 64'(rise_cyc[0] - last_hi[0]), 64'(3 + A_F + A_D));
      end
    end

    $display("[TB] reset in the middle of a pulse");
    drive(0, 1'b1);
    last_hi[0] = cyc + 1;
    repeat (3 + A_F + A_D + 100) @(negedge clk);
    checkOutput("pulse_before_reset", 64'(trig_a), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_async_trig", 64'(trig_a), 64'd0);
    checkOutput("reset_async_busy", 64'(busy_a), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (800) @(negedge clk);
    checkOutput("held_high_no_pulse", 64'(seen[0]), 64'd3);
    checkOutput("held_high_idle", 64'(busy_a), 64'd0);
    applyStimulus(0, 20, 700);
    checkOutput("rearmed_pulse", 64'(seen[0]), 64'd4);
    applyStimulus(0, 2000, 0);

    $display("[TB] zero delay / zero holdoff back-to-back edges");
    applyStimulus(1, 20, 16);
    checkOutput("latency_b", 64'(rise_cyc[1] - last_hi[1]), 64'(3 + B_F + B_D));
    for (int i = 0; i < 4; i++) applyStimulus(1, 16, 16);
    applyStimulus(1, 40, 0);
    checkOutput("b2b_pulses", 64'(seen[1]), 64'd5);

    $display("[TB] randomized stimulus against reference model");
    fork
      for (int i = 0; i < 40; i++)
        applyStimulus(0, int'($urandom_range(1, 400)), int'($urandom_range(1, 400)));
      for (int i = 0; i < 300; i++)
        applyStimulus(1, int'($urandom_range(1, 40)), int'($urandom_range(1, 40)));
    join
    drive(0, 1'b0);
    drive(1, 1'b0);
    repeat (2000) @(negedge clk);
    checkOutput("final_a_idle", 64'(busy_a), 64'd0);
    checkOutput("final_b_idle", 64'(busy_b), 64'd0);
`ifdef EVR_TRIG_STATS_EN
    checkOutput("final_a_trig_count", 64'(tc_a), 64'(pulses_m[0]));
    checkOutput("final_a_missed_count", 64'(mc_a), 64'(missed_m[0]));
    checkOutput("final_b_trig_count", 64'(tc_b), 64'(pulses_m[1]));
    checkOutput("final_b_missed_count", 64'(mc_b), 64'(missed_m[1]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
